// File: rtl/hub75_framebuffer_if.sv
// hub75_framebuffer_if
// Bundles the framebuffer's pixel-write port, control pulses and scan-read
// port into one interface.
//   master : the side that writes pixels, issues clear/swap and reads columns
//            (pixel source plus scan driver).
//   slave  : the framebuffer itself.
// Signals:
//   wr_valid/wr_ready/wr_x/wr_y/wr_rgb : pixel write handshake into the back bank
//   clear_req, swap_req, frame_end     : one-cycle control pulses
//   rd_en/rd_row/rd_col/rd_data        : front-bank read, one cycle latency
//   busy, swap_done, front_bank        : status
interface hub75_framebuffer_if #(
   parameter int COL_BITS = 6,
   parameter int ROW_BITS = 5
);
   logic                wr_valid;
   logic                wr_ready;
   logic [COL_BITS-1:0] wr_x;
   logic [ROW_BITS:0]   wr_y;
   logic [2:0]          wr_rgb;
   logic                clear_req;
   logic                swap_req;
   logic                frame_end;
   logic                rd_en;
   logic [ROW_BITS-1:0] rd_row;
   logic [COL_BITS-1:0] rd_col;
   logic [5:0]          rd_data;
   logic                busy;
   logic                swap_done;
   logic                front_bank;

   modport master (
      output wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_end,
             rd_en, rd_row, rd_col,
      input  wr_ready, rd_data, busy, swap_done, front_bank
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_end,
             rd_en, rd_row, rd_col,
      output wr_ready, rd_data, busy, swap_done, front_bank
   );
endinterface

// File: rtl/hub75_framebuffer.sv
// hub75_framebuffer
// Double-buffered 64x64, 1-bit-per-colour image store for a HUB75 scan driver.
// Pixel writes go to the back bank; the driver reads the front bank one column
// at a time, receiving the upper and lower half-row pixels in one word.
// Front/back exchange only happens on a frame boundary so the display never tears.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   fb  : hub75_framebuffer_if.slave (write port, control pulses, read port, status)
module hub75_framebuffer #(
   parameter int COLS      = 64,
   parameter int HALF_ROWS = 32,
   parameter int COL_BITS  = 6,
   parameter int ROW_BITS  = 5
) (
   input  logic               clk,
   input  logic               rst,
   hub75_framebuffer_if.slave fb
);
   localparam int            AW        = ROW_BITS + COL_BITS;
   localparam int            DEPTH     = HALF_ROWS * COLS;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] clr_cnt_q;
   logic          swap_pending_q;
   logic          swap_pending_d;
   logic          front_bank_q;
   logic          swap_done_q;
   logic          wr_ready_q;
   logic          busy_q;
   logic          rd_bank_q;
   logic          rd_valid_q;

   logic          clearing;
   logic          clear_start;
   logic          clear_last;
   logic          swap_fire;
   logic          wr_accept;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [2:0]    wr_data;
   logic [2:0]    top_sel;
   logic [2:0]    bot_sel;

   assign clearing    = (state_q == CLEAR);
   assign clear_start = (state_q == IDLE) && fb.clear_req;
   assign clear_last  = clearing && (clr_cnt_q == LAST_ADDR);
   // A pending swap is held off while clearing so a half-cleared bank is never shown.
   assign swap_fire   = fb.frame_end && swap_pending_q && !clearing;
   assign wr_accept   = fb.wr_valid && wr_ready_q;

   assign state_d        = clear_start ? CLEAR : (clear_last ? IDLE : state_q);
   // The swap_req term only matters when no swap fires, so a swap_req landing
   // on a frame_end just arms the swap for the following frame.
   assign swap_pending_d = swap_fire ? 1'b0 : (fb.swap_req ? 1'b1 : swap_pending_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         clr_cnt_q      <= '0;
         swap_pending_q <= 1'b0;
         front_bank_q   <= 1'b0;
         swap_done_q    <= 1'b0;
         wr_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         rd_bank_q      <= 1'b0;
         rd_valid_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear_start) begin
            clr_cnt_q <= '0;
         end else if (clearing) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
         end
         swap_pending_q <= swap_pending_d;
         if (swap_fire) begin
            front_bank_q <= ~front_bank_q;
         end
         swap_done_q <= swap_fire;
         // Status outputs are registered from next-state values so they track
         // the current state exactly with no combinational path to the outputs.
         wr_ready_q  <= (state_d == IDLE) && !swap_pending_d;
         busy_q      <= (state_d == CLEAR) || swap_pending_d;
         // Remember which bank the read addressed; a read on the swap cycle
         // therefore still returns the old front bank.
         if (fb.rd_en) begin
            rd_bank_q  <= front_bank_q;
            rd_valid_q <= 1'b1;
         end
      end
   end

   assign wr_addr = clearing ? clr_cnt_q : {fb.wr_y[ROW_BITS-1:0], fb.wr_x};
   assign wr_data = clearing ? 3'b000 : fb.wr_rgb;
   assign rd_addr = {fb.rd_row, fb.rd_col};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : bank_g
         logic       is_back;
         logic       we_top;
         logic       we_bot;
         logic [2:0] mem_top [DEPTH];
         logic [2:0] mem_bot [DEPTH];
         logic [2:0] top_rd_q;
         logic [2:0] bot_rd_q;

         assign is_back = (front_bank_q != 1'(gi));
         // Clearing zeroes both halves at once; a pixel write picks its half by wr_y MSB.
         assign we_top  = is_back && (clearing || (wr_accept && !fb.wr_y[ROW_BITS]));
         assign we_bot  = is_back && (clearing || (wr_accept &&  fb.wr_y[ROW_BITS]));

         always_ff @(posedge clk) begin
            if (we_top) begin
               mem_top[wr_addr] <= wr_data;
            end
            if (we_bot) begin
               mem_bot[wr_addr] <= wr_data;
            end
            if (fb.rd_en) begin
               top_rd_q <= mem_top[rd_addr];
               bot_rd_q <= mem_bot[rd_addr];
            end
         end
      end
   endgenerate

   assign top_sel = rd_bank_q ? bank_g[1].top_rd_q : bank_g[0].top_rd_q;
   assign bot_sel = rd_bank_q ? bank_g[1].bot_rd_q : bank_g[0].bot_rd_q;

   // Memory read registers are not reset, so the output is masked to zero
   // until the first read after reset.
   assign fb.rd_data    = rd_valid_q ? {top_sel[2], bot_sel[2], top_sel[1], bot_sel[1],
                                        top_sel[0], bot_sel[0]} : 6'b000000;
   assign fb.wr_ready   = wr_ready_q;
   assign fb.busy       = busy_q;
   assign fb.swap_done  = swap_done_q;
   assign fb.front_bank = front_bank_q;
endmodule

// File: tb/tb_hub75_framebuffer.sv
// tb_hub75_framebuffer
// Drives hub75_framebuffer with directed phases and randomized traffic. A
// picture-level model (two 64x64 images, a front index, a pending flag and a
// clear countdown) predicts every output; read expectations go through a queue
// that a separate monitor drains.
module tb_hub75_framebuffer;
   logic clk = 1'b0;
   logic rst = 1'b0;

   hub75_framebuffer_if bus ();

   hub75_framebuffer dut (
      .clk (clk),
      .rst (rst),
      .fb  (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference picture store: img[bank][y][x], y 0..63 across the whole panel.
   logic [2:0] img [2][64][64];
   int  m_front     = 0;
   bit  m_pending   = 1'b0;
   int  m_left      = 0;
   bit  m_swap_done = 1'b0;
   bit  m_rd_seen   = 1'b0;

   typedef struct {
      int         row;
      int         col;
      logic [5:0] data;
   } rd_t;
   rd_t rd_q[$];
   logic [5:0] last_rd = 6'b000000;

   function automatic logic [5:0] pack(input logic [2:0] t, input logic [2:0] b);
      return {t[2], b[2], t[1], b[1], t[0], b[0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, updated on every active edge from the inputs of that cycle.
   initial begin
      bit in_clear;
      bit acc;
      bit fire;
      for (int b = 0; b < 2; b++)
         for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
               img[b][y][x] = 3'b000;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_front     = 0;
            m_pending   = 1'b0;
            m_left      = 0;
            m_swap_done = 1'b0;
            m_rd_seen   = 1'b0;
            rd_q.delete();
         end else begin
            in_clear  = (m_left > 0);
            acc       = bus.wr_valid && !in_clear && !m_pending;
            m_rd_seen = bus.rd_en;
            if (bus.rd_en) begin
               rd_q.push_back('{int'(bus.rd_row), int'(bus.rd_col),
                  pack(img[m_front][int'(bus.rd_row)][int'(bus.rd_col)],
                       img[m_front][int'(bus.rd_row) + 32][int'(bus.rd_col)])});
            end
            if (acc) img[1 - m_front][int'(bus.wr_y)][int'(bus.wr_x)] = bus.wr_rgb;
            fire        = bus.frame_end && m_pending && !in_clear;
            m_swap_done = fire;
            if (fire) m_front = 1 - m_front;
            if (fire) m_pending = 1'b0;
            else if (bus.swap_req) m_pending = 1'b1;
            if (in_clear) begin
               m_left--;
            end else if (bus.clear_req) begin
               m_left = 2048;
               for (int y = 0; y < 64; y++)
                  for (int x = 0; x < 64; x++)
                     img[1 - m_front][y][x] = 3'b000;
            end
         end
      end
   end

   // Monitor: compares status every cycle and pops a read expectation whenever
   // the DUT presents the result of a read.
   initial begin
      rd_t r;
      forever begin
         @(negedge clk);
         if (rst) last_rd = 6'b000000;
         check("wr_ready", 32'(bus.wr_ready), 32'(!rst && m_left == 0 && !m_pending));
         check("busy", 32'(bus.busy), 32'(m_left > 0 || m_pending));
         check("front_bank", 32'(bus.front_bank), 32'(m_front));
         check("swap_done", 32'(bus.swap_done), 32'(m_swap_done));
         if (!rst && m_rd_seen) begin
            if (rd_q.size() == 0) begin
               check("rd_queue_empty", 32'd1, 32'd0);
            end else begin
               r       = rd_q.pop_front();
               last_rd = r.data;
               $display("read row=%0d col=%0d data=%b expected=%b", r.row, r.col,
                        bus.rd_data, r.data);
            end
         end
         check("rd_data", 32'(bus.rd_data), 32'(last_rd));
      end
   end

   task automatic next();
      @(negedge clk);
      bus.wr_valid  = 1'b0;
      bus.clear_req = 1'b0;
      bus.swap_req  = 1'b0;
      bus.frame_end = 1'b0;
      bus.rd_en     = 1'b0;
   endtask

   task automatic do_write(input int x, input int y, input int rgb);
      int n = 0;
      while (!bus.wr_ready && n < 5000) begin
         next();
         n++;
      end
      if (n >= 5000) check("write_timeout", 32'd1, 32'd0);
      bus.wr_valid = 1'b1;
      bus.wr_x     = 6'(x);
      bus.wr_y     = 6'(y);
      bus.wr_rgb   = 3'(rgb);
      next();
   endtask

   task automatic swap_now();
      bus.swap_req = 1'b1;
      next();
      bus.frame_end = 1'b1;
      next();
   endtask

   // Starts a clear and returns the number of cycles busy stayed high.
   task automatic clear_full(output int n);
      bus.clear_req = 1'b1;
      next();
      n = 0;
      while (bus.busy && n < 3000) begin
         next();
         n++;
      end
   endtask

   task automatic settle();
      int n = 0;
      while (bus.busy && n < 5000) begin
         bus.frame_end = (n % 100 == 99);
         next();
         n++;
      end
      if (n >= 5000) check("settle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
      bus.clear_req = 1'b0; bus.swap_req = 1'b0; bus.frame_end = 1'b0;
      bus.rd_en = 1'b0; bus.rd_row = '0; bus.rd_col = '0;

      // Reset
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("reset_rd_data", 32'(bus.rd_data), 32'd0);
      #2 rst = 1'b0;
      next();
      check("wr_ready_after_reset", 32'(bus.wr_ready), 32'd1);

      // Clear both banks, measure clear length
      clear_full(n);
      check("clear_len", 32'(n), 32'd2048);
      swap_now();
      check("front_after_swap", 32'(bus.front_bank), 32'd1);
      clear_full(n);
      check("clear_len_b0", 32'(n), 32'd2048);
      swap_now();
      for (int i = 0; i < 8; i++) begin
         bus.rd_en  = 1'b1;
         bus.rd_row = 5'($urandom_range(0, 31));
         bus.rd_col = 6'($urandom_range(0, 63));
         next();
         check("zero_read", 32'(bus.rd_data), 32'd0);
      end

      // Two pixels in the same column, upper and lower half
      do_write(5, 3, 5);
      do_write(5, 35, 3);
      swap_now();
      bus.rd_en = 1'b1; bus.rd_row = 5'd3; bus.rd_col = 6'd5;
      next();
      check("pix_5_3", 32'(bus.rd_data), 32'h27);

      // Long pending swap
      bus.swap_req = 1'b1;
      next();
      repeat (500) next();
      check("pend_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("pend_busy", 32'(bus.busy), 32'd1);
      check("pend_front", 32'(bus.front_bank), 32'd1);
      bus.frame_end = 1'b1;
      next();
      check("pend_swapped", 32'(bus.front_bank), 32'd0);
      check("pend_ready_back", 32'(bus.wr_ready), 32'd1);

      // Swap requested during a clear is deferred past the clear
      bus.clear_req = 1'b1;
      next();
      bus.swap_req = 1'b1;
      next();
      repeat (97) next();
      bus.frame_end = 1'b1;
      next();
      check("no_swap_in_clear", 32'(bus.front_bank), 32'd0);
      repeat (2000) next();
      bus.frame_end = 1'b1;
      next();
      check("swap_after_clear", 32'(bus.front_bank), 32'd1);

      // Streaming reads across a swap
      do_write(7, 9, 7);
      do_write(7, 41, 7);
      bus.swap_req = 1'b1;
      next();
      for (int i = 0; i < 40; i++) begin
         bus.rd_en = 1'b1; bus.rd_row = 5'd9; bus.rd_col = 6'd7;
         if (i == 20) bus.frame_end = 1'b1;
         next();
         if (i == 20) check("stream_old", 32'(bus.rd_data), 32'd0);
         if (i == 21) check("stream_new", 32'(bus.rd_data), 32'h3f);
      end

      // Randomized traffic
      for (int i = 0; i < 6000; i++) begin
         bus.wr_valid  = 1'($urandom_range(0, 1));
         bus.wr_x      = 6'($urandom_range(0, 63));
         bus.wr_y      = 6'($urandom_range(0, 63));
         bus.wr_rgb    = 3'($urandom_range(0, 7));
         bus.rd_en     = 1'($urandom_range(0, 1));
         bus.rd_row    = 5'($urandom_range(0, 31));
         bus.rd_col    = 6'($urandom_range(0, 63));
         bus.swap_req  = ($urandom_range(0, 49) == 0);
         bus.frame_end = ($urandom_range(0, 29) == 0);
         bus.clear_req = ($urandom_range(0, 1999) == 0);
         next();
      end

      // Reset in the middle of a clear
      settle();
      bus.clear_req = 1'b1;
      next();
      repeat (999) next();
      #2 rst = 1'b1;
      @(negedge clk);
      check("midclr_busy", 32'(bus.busy), 32'd0);
      check("midclr_front", 32'(bus.front_bank), 32'd0);
      check("midclr_rd_data", 32'(bus.rd_data), 32'd0);
      check("midclr_wr_ready", 32'(bus.wr_ready), 32'd0);
      #2 rst = 1'b0;
      next();
      check("midclr_ready_after", 32'(bus.wr_ready), 32'd1);
      clear_full(n);
      check("clear_len_after_rst", 32'(n), 32'd2048);
      swap_now();
      clear_full(n);
      check("clear_len_after_rst_b0", 32'(n), 32'd2048);
      swap_now();
      for (int i = 0; i < 64; i++) begin
         bus.rd_en  = 1'b1;
         bus.rd_row = 5'($urandom_range(0, 31));
         bus.rd_col = 6'($urandom_range(0, 63));
         next();
         check("post_rst_zero", 32'(bus.rd_data), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
